// File: rtl/banco_fifos_salida.sv
// Four-lane output FIFO bank fed by the class arbiter.
// Registered occupancy counters drive all flags; errors are sticky.
module banco_fifos_salida #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            push,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [3:0]            pop,
  input  logic [PTR_W:0]        umbral_af,
  input  logic [PTR_W:0]        umbral_ae,
  output logic [4*DATA_W-1:0]   data_out,
  output logic [3:0]            valid_out,
  output logic [3:0]            empty,
  output logic [3:0]            full,
  output logic [3:0]            almost_full,
  output logic [3:0]            almost_empty,
  output logic [3:0]            error
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0]   mem_q    [4][DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q [4];
  logic [PTR_W-1:0]    rd_ptr_q [4];
  logic [PTR_W:0]      cnt_q    [4];
  logic [PTR_W:0]      cnt_d    [4];
  logic [4*DATA_W-1:0] dout_q;
  logic [3:0]          valid_q;
  logic [3:0]          err_q;
  logic [3:0]          wr_en;
  logic [3:0]          rd_en;
  logic [3:0]          err_set;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i]        = (cnt_q[i] == '0);
      full[i]         = (cnt_q[i] == DEPTH_C);
      almost_full[i]  = (cnt_q[i] >= umbral_af);
      almost_empty[i] = (cnt_q[i] <= umbral_ae);
    end
  end

  // Pop on an empty lane never bypasses a same-cycle push.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_en[i]   = push[i] && (!full[i] || pop[i]);
      rd_en[i]   = pop[i] && !empty[i];
      err_set[i] = (push[i] && full[i] && !pop[i])
                 || (pop[i] && empty[i]);
      cnt_d[i]   = cnt_q[i];
      if (wr_en[i] && !rd_en[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rd_en[i] && !wr_en[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wr_ptr_q[i]] <= data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      dout_q  <= '0;
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        end
        if (rd_en[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
          dout_q[i*DATA_W +: DATA_W] <= mem_q[i][rd_ptr_q[i]];
        end
        cnt_q[i] <= cnt_d[i];
      end
      valid_q <= rd_en;
      err_q   <= err_q | err_set;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = valid_q;
  assign error     = err_q;

endmodule

// File: tb/tb_banco_fifos_salida.sv
// Self-checking bench for banco_fifos_salida.
// Queue-based reference model plus directed and random scenarios.
module tb_banco_fifos_salida;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  push = '0;
  logic [11:0] data_in = '0;
  logic [3:0]  pop = '0;
  logic [3:0]  umbral_af = 4'd6;
  logic [3:0]  umbral_ae = 4'd1;
  logic [47:0] data_out;
  logic [3:0]  valid_out;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  almost_full;
  logic [3:0]  almost_empty;
  logic [3:0]  error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] mq [4][$];
  logic [47:0] m_dout;
  logic [3:0]  m_valid;
  logic [3:0]  m_err;

  banco_fifos_salida dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in),
    .pop(pop), .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .data_out(data_out), .valid_out(valid_out), .empty(empty),
    .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_dout  = '0;
    m_valid = '0;
    m_err   = '0;
  endtask

  task automatic model_step(input logic [3:0] p,
                            input logic [3:0] pp,
                            input logic [11:0] d);
    for (int i = 0; i < 4; i++) begin
      int sz = mq[i].size();
      m_valid[i] = 1'b0;
      if (pp[i] && sz == 0) m_err[i] = 1'b1;
      if (p[i] && sz == 8 && !pp[i]) m_err[i] = 1'b1;
      if (pp[i] && sz > 0) begin
        m_dout[i*12 +: 12] = mq[i].pop_front();
        m_valid[i] = 1'b1;
      end
      if (p[i] && (sz < 8 || pp[i])) mq[i].push_back(d);
    end
  endtask

  // Drive one cycle, update the model at the edge, return #1 after it.
  task automatic tick(input logic [3:0] p, input logic [3:0] pp,
                      input logic [11:0] d);
    push = p;
    pop = pp;
    data_in = d;
    @(posedge clk);
    model_step(p, pp, d);
    #1;
    push = '0;
    pop = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (empty !== 4'hF) begin
      n_bad++; $display("FAIL reset_empty got %h want F", empty);
    end
    n_cmp++;
    if (full !== 4'h0) begin
      n_bad++; $display("FAIL reset_full got %h want 0", full);
    end
    n_cmp++;
    if (error !== 4'h0) begin
      n_bad++; $display("FAIL reset_error got %h want 0", error);
    end
    n_cmp++;
    if (valid_out !== 4'h0) begin
      n_bad++; $display("FAIL reset_valid got %h want 0", valid_out);
    end
    n_cmp++;
    if (data_out !== 48'h0) begin
      n_bad++; $display("FAIL reset_dout got %h want 0", data_out);
    end
    n_cmp++;
    if (almost_empty !== 4'hF || almost_full !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_almost ae %h af %h want F 0",
               almost_empty, almost_full);
    end
  endtask

  task automatic test_fill_drain();
    logic [11:0] exp [3] = '{12'h0AB, 12'h0DE, 12'h074};
    for (int k = 0; k < 3; k++) tick(4'b0001, 4'b0000, exp[k]);
    for (int k = 0; k < 3; k++) begin
      tick(4'b0000, 4'b0001, 12'h0);
      n_cmp++;
      if (data_out[11:0] !== exp[k] || valid_out[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_drain[%0d] got %h v%b want %h v1",
                 k, data_out[11:0], valid_out[0], exp[k]);
      end
    end
    n_cmp++;
    if (empty[0] !== 1'b1) begin
      n_bad++; $display("FAIL drain_empty got %b want 1", empty[0]);
    end
  endtask

  task automatic test_thresholds();
    umbral_af = 4'd6;
    umbral_ae = 4'd1;
    for (int j = 1; j <= 6; j++) begin
      tick(4'b0100, 4'b0000, 12'(12'h300 + j));
      n_cmp++;
      if (almost_full[2] !== (j >= 6) || almost_empty[2] !== (j <= 1)) begin
        n_bad++;
        $display("FAIL thresh[%0d] af %b ae %b want %b %b", j,
                 almost_full[2], almost_empty[2], j >= 6, j <= 1);
      end
    end
    for (int j = 0; j < 6; j++) tick(4'b0000, 4'b0100, 12'h0);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 9; k++) tick(4'b0100, 4'b0000, 12'(12'h800 + k));
    n_cmp++;
    if (full[2] !== 1'b1 || error[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow full %b err %b want 1 1", full[2], error[2]);
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'b0000, 4'b0100, 12'h0);
      n_cmp++;
      if (data_out[24 +: 12] !== 12'(12'h800 + k) || valid_out[2] !== 1'b1) begin
        n_bad++;
        $display("FAIL overflow_drain[%0d] got %h want %h",
                 k, data_out[24 +: 12], 12'(12'h800 + k));
      end
    end
    n_cmp++;
    if (empty[2] !== 1'b1) begin
      n_bad++; $display("FAIL overflow_empty got %b want 1", empty[2]);
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] first = 12'($urandom);
    tick(4'b1000, 4'b0000, first);
    for (int k = 1; k < 8; k++) tick(4'b1000, 4'b0000, 12'($urandom));
    tick(4'b1000, 4'b1000, 12'hFAB);
    n_cmp++;
    if (data_out[36 +: 12] !== first || full[3] !== 1'b1
        || error[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pushpop dout %h full %b err %b want %h 1 0",
               data_out[36 +: 12], full[3], error[3], first);
    end
    tick(4'b0010, 4'b0010, 12'h1C5);
    n_cmp++;
    if (error[1] !== 1'b1 || valid_out[1] !== 1'b0 || empty[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_pushpop err %b v %b empty %b want 1 0 0",
               error[1], valid_out[1], empty[1]);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) tick(4'b0011, 4'b0000, 12'(12'h500 + k));
    tick(4'b0010, 4'b0000, 12'h5FF);
    n_cmp++;
    if (empty !== 4'b0100 || full !== 4'b1000) begin
      n_bad++;
      $display("FAIL pre_reset empty %h full %h want 4 8", empty, full);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (empty !== 4'hF || full !== 4'h0 || error !== 4'h0
        || valid_out !== 4'h0 || data_out !== 48'h0) begin
      n_bad++;
      $display("FAIL async_reset e %h f %h err %h v %h d %h",
               empty, full, error, valid_out, data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    tick(4'b0010, 4'b0000, 12'h4AB);
    tick(4'b0000, 4'b0010, 12'h0);
    n_cmp++;
    if (data_out[12 +: 12] !== 12'h4AB || valid_out[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset got %h v %b want 4ab v1",
               data_out[12 +: 12], valid_out[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] e_empty, e_full, e_af, e_ae;
      if (c % 50 == 0) begin
        umbral_af = 4'($urandom_range(0, 8));
        umbral_ae = 4'($urandom_range(0, 8));
        #1;
      end
      tick(4'($urandom & $urandom_range(0, 15)),
           4'($urandom & $urandom_range(0, 15)), 12'($urandom));
      for (int i = 0; i < 4; i++) begin
        e_empty[i] = mq[i].size() == 0;
        e_full[i]  = mq[i].size() == 8;
        e_af[i]    = mq[i].size() >= int'(umbral_af);
        e_ae[i]    = mq[i].size() <= int'(umbral_ae);
      end
      n_cmp++;
      if (data_out !== m_dout || valid_out !== m_valid || error !== m_err
          || empty !== e_empty || full !== e_full
          || almost_full !== e_af || almost_empty !== e_ae) begin
        n_bad++;
        $display("FAIL random[%0d] d %h v %h err %h e %h f %h af %h ae %h want d %h v %h err %h e %h f %h af %h ae %h",
                 c, data_out, valid_out, error, empty, full, almost_full,
                 almost_empty, m_dout, m_valid, m_err, e_empty, e_full,
                 e_af, e_ae);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banco_fifos_salida.md
# banco_fifos_salida

Four-lane output FIFO bank sitting directly downstream of the class arbiter. It accepts the arbiter's one-hot `push[3:0]` and shared 12-bit data word. It returns per-lane `almost_full[3:0]` back-pressure so the arbiter can stall, and presents per-lane `empty`/`data_out` to the consumer. All flags derive from registered occupancy counters; overflow and underflow are trapped in sticky per-lane error bits.

## Interface
- `DATA_W`, 12: word width; full arbiter word, class bits [11:10] included.
- `DEPTH`, 8: entries per lane; power of two, at least 4.
- `PTR_W`, 3: log2(DEPTH).
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: one clock; reset is asynchronous and active-low (`reset`=0 clears state immediately; release is synchronous to `clk` in the system).
- `push` input 4: per-lane write strobe from the arbiter.
- `data_in` input DATA_W: word written to every lane whose `push` bit is set.
- `pop` input 4: per-lane read strobe from the consumer.
- `umbral_af` input PTR_W+1: almost-full threshold, shared by all lanes.
- `umbral_ae` input PTR_W+1: almost-empty threshold, shared by all lanes.
- `data_out` output 4*DATA_W: lane i occupies bits [i*DATA_W +: DATA_W]; registered.
- `valid_out` output 4: lane i `data_out` holds a word popped on the previous edge.
- `empty` output 4: count[i]==0.
- `full` output 4: count[i]==DEPTH.
- `almost_full` output 4: count[i] >= `umbral_af`.
- `almost_empty` output 4: count[i] <= `umbral_ae`.
- `error` output 4: sticky overflow/underflow flag per lane.

## Operation
- Each lane has a DEPTH x DATA_W memory, wr_ptr and rd_ptr (PTR_W bits, natural wrap at DEPTH), and count (PTR_W+1 bits, 0..DEPTH).
- Write on posedge when `push[i]` and (!full[i] or `pop[i]`): mem[wr_ptr] <= `data_in`, wr_ptr++.
- Read on posedge when `pop[i]` and !empty[i]: data_out lane <= mem[rd_ptr], rd_ptr++, valid_out[i] <= 1.
- Otherwise valid_out[i] <= 0 and data_out lane holds its value.
- count: +1 on a write only, -1 on a read only, unchanged on both or neither.
- Flags `empty`, `full`, `almost_full` and `almost_empty` are combinational from count and the threshold ports; they contain no extra register stage.
- Multiple `push` bits set in one cycle: the same word is written to each enabled lane. This is legal; the arbiter does not do it.
- Boundary conditions:
  - Push to full lane without pop: write dropped, pointers and count unchanged, error[i] <= 1.
  - Push and pop on full lane: both performed, count stays DEPTH, no error.
  - Pop on empty lane: no read, valid_out[i]=0, data_out holds, error[i] <= 1. This applies even with a simultaneous push (no bypass). The push still completes, so count becomes 1.
  - error[i] is cleared only by reset.
- Reset (async, `reset`=0): pointers, counts, `data_out`, `valid_out` and `error` all go to 0. Flags therefore read empty=4'hF, full=0, almost_empty=4'hF (when `umbral_ae` >= 0), and almost_full=0 (when `umbral_af` > 0). Memory contents are not cleared.
- Reset asserted mid-transfer aborts everything in flight. The first write after release lands at entry 0.

## Timing
- Write latency: word pushed at edge N is poppable at edge N+1. `empty[i]` falls right after edge N.
- Read latency: `pop` sampled at edge N gives `data_out`/`valid_out` valid after edge N, for one cycle.
- Back-pressure: `almost_full` updates the cycle after the push that crosses the threshold. The arbiter relies on `umbral_af` <= DEPTH-1 to absorb one in-flight push.
- Thresholds may change at any time; flags follow combinationally.

## Test plan
- Reset check: hold `reset`=0 for 2 cycles, then release. Expect empty=4'hF, full=0, error=0, valid_out=0, data_out=0.
- Fill/drain lane 0: push 'h0AB, 'h0DE, 'h074 on lane 0, then pop 3 times. Expect data_out[11:0] sequence 'h0AB, 'h0DE, 'h074 with valid_out[0]=1 each cycle, and empty[0]=1 at the end.
- Threshold flags: `umbral_af`=6, `umbral_ae`=1. Push 6 words to lane 2. Expect almost_full[2] to rise after the 6th edge and almost_empty[2] to fall after the 2nd edge.
- Overflow: push 9 words ('h800..'h808) to lane 2 with DEPTH=8. Expect full[2]=1, error[2]=1, and 'h808 dropped. Draining returns 'h800..'h807 only.
- Simultaneous events: with lane 3 full, push 'hFAB and pop in the same cycle. Expect count to stay 8, no error, and the oldest word out. With lane 1 empty, push+pop in the same cycle: expect error[1]=1, valid_out[1]=0, empty[1]=0.
- Reset mid-operation: with lanes at counts 3/5/0/8, assert `reset`=0 asynchronously between edges. Outputs clear immediately. After release, push 'h4AB on lane 1 and pop it: expect 'h4AB.
